// File: rtl/score_font_pkg.sv
// Font data and BCD helpers shared by the score digit renderer.
package score_font_pkg;

  localparam int unsigned DIGIT_W = 8;
  localparam int unsigned DIGIT_H = 16;
  localparam int unsigned BCD_MAX = 9;

  typedef logic [3:0] bcd_t;
  typedef logic [7:0] font_row_t;

  // Bit 7 of each row is the leftmost column of the glyph.
  localparam font_row_t FONT [0:9][0:15] = '{
    '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h06, 8'h06, 8'h0C, 8'h0C, 8'h18, 8'h18, 8'h30, 8'h30, 8'h60, 8'h60, 8'h66, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h06, 8'h06, 8'h1C, 8'h1C, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h6C, 8'hCC, 8'hCC, 8'hFE, 8'hFE, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h1E, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h60, 8'h60, 8'h7C, 8'h66, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h7E, 8'h66, 8'h06, 8'h06, 8'h0C, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00}
  };

  function automatic logic bcd_invalid(input bcd_t n);
    return n > 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/score_digits_renderer_if.sv
// Score input, pixel position and drawing outputs between the video pipeline and the renderer.
interface score_digits_renderer_if;
  logic [11:0] Score;
  logic        frame_start;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        bcd_error;

  modport master (
    output Score, frame_start, pixelX, pixelY,
    input  drawingRequest, RGBout, bcd_error
  );

  modport slave (
    input  Score, frame_start, pixelX, pixelY,
    output drawingRequest, RGBout, bcd_error
  );
endinterface

// File: rtl/digit_font_rom.sv
// Registered glyph lookup: one cycle from (digit,row,column) to lit bit and pixel colour.
module digit_font_rom
  import score_font_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  bcd_t       digit,
  input  logic [3:0] row,
  input  logic [2:0] col,
  input  logic [7:0] color,
  output logic       lit,
  output logic [7:0] rgb
);

  logic bit_c;

  // Invalid digits never reach the table; the caller also gates them off via en.
  always_comb begin
    bit_c = 1'b0;
    if (!bcd_invalid(digit)) bit_c = FONT[digit][row][~col];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lit <= 1'b0;
      rgb <= 8'h00;
    end else begin
      lit <= en & bit_c;
      rgb <= (en & bit_c) ? color : 8'h00;
    end
  end

endmodule

// File: rtl/score_digits_renderer.sv
// Draws the frame-latched 3-digit BCD score as scaled glyphs, flashing after each score change.
module score_digits_renderer
  import score_font_pkg::*;
#(
  parameter int unsigned TOPLEFT_X     = 16,
  parameter int unsigned TOPLEFT_Y     = 8,
  parameter int unsigned SCALE_LOG2    = 1,
  parameter int unsigned DIGIT_GAP     = 4,
  parameter logic [7:0]  FG_COLOR      = 8'hFF,
  parameter logic [7:0]  FLASH_COLOR   = 8'hFC,
  parameter int unsigned FLASH_FRAMES  = 30,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  score_digits_renderer_if.slave   bus
);

  localparam int unsigned GLYPH_W = DIGIT_W << SCALE_LOG2;
  localparam int unsigned GLYPH_H = DIGIT_H << SCALE_LOG2;
  localparam int unsigned PITCH   = GLYPH_W + DIGIT_GAP;
  localparam int unsigned X_HUN   = TOPLEFT_X;
  localparam int unsigned X_TEN   = TOPLEFT_X + PITCH;
  localparam int unsigned X_UNI   = TOPLEFT_X + 2 * PITCH;
  localparam int unsigned Y_END   = TOPLEFT_Y + GLYPH_H;

  logic [11:0] score_q;
  logic [7:0]  flash_cnt;
  logic        first_frame;
  logic        bcd_error_q;

  bcd_t hun, ten, uni;
  logic blank_hun, blank_ten, blank_uni;

  logic [31:0] px, py, left_c, dx, dy;
  logic        in_y, hit_hun, hit_ten, hit_uni, in_box_c, blank_c;
  bcd_t        nib_c;
  logic [3:0]  row_c;
  logic [2:0]  col_c;

  logic        s1_valid, s1_in_box, s1_blank;
  bcd_t        s1_nib;
  logic [3:0]  s1_row;
  logic [2:0]  s1_col;
  logic        rom_en;
  logic [7:0]  color_c;
  logic        lit;
  logic [7:0]  rgb;

  // Per-frame score latch, change-triggered flash counter and sticky BCD error.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q     <= 12'h000;
      flash_cnt   <= 8'h00;
      first_frame <= 1'b1;
      bcd_error_q <= 1'b0;
    end else if (bus.frame_start) begin
      score_q     <= bus.Score;
      first_frame <= 1'b0;
      if (bus.Score != score_q && !first_frame) flash_cnt <= 8'(FLASH_FRAMES);
      else if (flash_cnt != 8'h00)              flash_cnt <= flash_cnt - 8'd1;
      if (bcd_invalid(bus.Score[11:8]) || bcd_invalid(bus.Score[7:4]) ||
          bcd_invalid(bus.Score[3:0]))
        bcd_error_q <= 1'b1;
    end
  end

  always_comb begin
    hun       = score_q[11:8];
    ten       = score_q[7:4];
    uni       = score_q[3:0];
    blank_hun = bcd_invalid(hun) || (BLANK_LEADING && hun == 4'd0);
    blank_ten = bcd_invalid(ten) || (BLANK_LEADING && hun == 4'd0 && ten == 4'd0);
    blank_uni = bcd_invalid(uni);
  end

  // Box membership is decided by compares first, so the subtractions below never matter outside it.
  always_comb begin
    px       = 32'(bus.pixelX);
    py       = 32'(bus.pixelY);
    in_y     = (py >= TOPLEFT_Y) && (py < Y_END);
    hit_hun  = (px >= X_HUN) && (px < X_HUN + GLYPH_W);
    hit_ten  = (px >= X_TEN) && (px < X_TEN + GLYPH_W);
    hit_uni  = (px >= X_UNI) && (px < X_UNI + GLYPH_W);
    in_box_c = in_y && (hit_hun || hit_ten || hit_uni);
    left_c   = hit_hun ? X_HUN : (hit_ten ? X_TEN : X_UNI);
    nib_c    = hit_hun ? hun : (hit_ten ? ten : uni);
    blank_c  = hit_hun ? blank_hun : (hit_ten ? blank_ten : blank_uni);
    dx       = px - left_c;
    dy       = py - TOPLEFT_Y;
    col_c    = 3'(dx >> SCALE_LOG2);
    row_c    = 4'(dy >> SCALE_LOG2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_in_box <= 1'b0;
      s1_blank  <= 1'b1;
      s1_nib    <= 4'd0;
      s1_row    <= 4'd0;
      s1_col    <= 3'd0;
    end else begin
      s1_valid  <= 1'b1;
      s1_in_box <= in_box_c;
      s1_blank  <= blank_c;
      s1_nib    <= nib_c;
      s1_row    <= row_c;
      s1_col    <= col_c;
    end
  end

  always_comb begin
    rom_en  = s1_valid & s1_in_box & ~s1_blank;
    color_c = (flash_cnt != 8'h00) ? FLASH_COLOR : FG_COLOR;
  end

  digit_font_rom u_rom (
    .clk   (clk),
    .reset (reset),
    .en    (rom_en),
    .digit (s1_nib),
    .row   (s1_row),
    .col   (s1_col),
    .color (color_c),
    .lit   (lit),
    .rgb   (rgb)
  );

  assign bus.drawingRequest = lit;
  assign bus.RGBout         = rgb;
  assign bus.bcd_error      = bcd_error_q;

endmodule

// File: tb/tb_score_digits_renderer.sv
// Directed and randomized checks of the score digit renderer against a frame-level reference model.
module tb_score_digits_renderer;
  import score_font_pkg::*;

  localparam int TLX = 16, TLY = 8, SC = 1, GAP = 4, NFLASH = 30;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [11:0] m_score;
  bit          m_first, m_err;
  int          m_since;

  always #5 clk = ~clk;

  score_digits_renderer_if bus ();

  score_digits_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_lit(input int x, input int y);
    int w, hgt, p, left, n, hu, te, row, col;
    bit blank;
    font_row_t r;
    w   = 8 << SC;
    hgt = 16 << SC;
    p   = w + GAP;
    hu  = int'(m_score[11:8]);
    te  = int'(m_score[7:4]);
    for (int d = 0; d < 3; d++) begin
      left = TLX + d * p;
      if (x >= left && x < left + w && y >= TLY && y < TLY + hgt) begin
        n     = int'((m_score >> (4 * (2 - d))) & 12'h00F);
        blank = (n > 9) || (d == 0 && hu == 0) || (d == 1 && hu == 0 && te == 0);
        if (blank) return 1'b0;
        row = (y - TLY) / (1 << SC);
        col = (x - left) / (1 << SC);
        r   = FONT[n][row];
        return r[7 - col];
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_score = 12'h000;
    m_first = 1'b1;
    m_err   = 1'b0;
    m_since = 1000;
  endtask

  task automatic pulse(input logic [11:0] s);
    bus.Score       = s;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    if (!m_first && s != m_score) m_since = 0;
    else if (m_since < 1000)      m_since++;
    m_first = 1'b0;
    m_score = s;
    if (s[11:8] > 4'd9 || s[7:4] > 4'd9 || s[3:0] > 4'd9) m_err = 1'b1;
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input logic exp_dr, input logic [7:0] exp_rgb);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    tick();
    tick();
    check({tag, "_dr"}, 32'(bus.drawingRequest), 32'(exp_dr));
    check({tag, "_rgb"}, 32'(bus.RGBout), 32'(exp_rgb));
  endtask

  task automatic probe_model(input string tag, input int x, input int y);
    bit lit;
    lit = model_lit(x, y);
    probe(tag, x, y, lit, lit ? ((m_since < NFLASH) ? 8'hFC : 8'hFF) : 8'h00);
  endtask

  initial begin
    logic [11:0] s;
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.Score       = 12'h000;
    bus.pixelX      = 11'd0;
    bus.pixelY      = 11'd0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    check("rst_dr", 32'(bus.drawingRequest), 32'd0);
    check("rst_rgb", 32'(bus.RGBout), 32'd0);
    check("rst_err", 32'(bus.bcd_error), 32'd0);

    // Zero score: only the units digit shows.
    pulse(12'h000);
    probe("t1_units0", 60, 8, 1'b1, 8'hFF);
    probe("t1_hun_blank", 20, 8, 1'b0, 8'h00);

    // Score change flashes for a fixed number of frames.
    pulse(12'h105);
    probe("t2_tens0_flash", 40, 10, 1'b1, 8'hFC);
    for (int k = 1; k < NFLASH; k++) begin
      pulse(12'h105);
      probe($sformatf("t2_flash_%0d", k), 40, 10, 1'b1, 8'hFC);
    end
    pulse(12'h105);
    probe("t2_flash_done", 40, 10, 1'b1, 8'hFF);

    // Score changes between frame pulses are ignored.
    bus.Score = 12'h999;
    probe("t3_tens_hold", 40, 10, 1'b1, 8'hFF);
    probe("t3_units_hold", 60, 8, 1'b1, 8'hFF);
    probe("t3_gap_hold", 58, 8, 1'b1, 8'hFF);

    // Invalid tens nibble blanks that digit and sets a sticky error.
    pulse(12'h0A3);
    probe("t4_tens_blank", 40, 10, 1'b0, 8'h00);
    check("t4_err_set", 32'(bus.bcd_error), 32'd1);
    probe("t4_units3", 60, 8, 1'b1, 8'hFC);
    pulse(12'h023);
    check("t4_err_sticky", 32'(bus.bcd_error), 32'd1);
    probe("t4_tens2", 40, 10, 1'b1, 8'hFC);

    // Outside and gap pixels.
    probe("t5_gap", 33, 20, 1'b0, 8'h00);
    probe("t5_right", 72, 20, 1'b0, 8'h00);
    probe("t5_below", 60, 40, 1'b0, 8'h00);
    probe("t5_left", 10, 20, 1'b0, 8'h00);

    // Reset during a flash wins over a simultaneous frame pulse.
    reset           = 1'b1;
    bus.frame_start = 1'b1;
    bus.Score       = 12'h777;
    tick();
    reset           = 1'b0;
    bus.frame_start = 1'b0;
    model_reset();
    check("t6_dr", 32'(bus.drawingRequest), 32'd0);
    check("t6_rgb", 32'(bus.RGBout), 32'd0);
    check("t6_err", 32'(bus.bcd_error), 32'd0);
    probe("t6_score0_col1", 58, 8, 1'b0, 8'h00);
    probe("t6_score0_col2", 60, 8, 1'b1, 8'hFF);
    pulse(12'h456);
    probe("t6_no_flash", 60, 8, 1'b1, 8'hFF);

    // Randomized pixels and frame updates against the reference model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 9) == 0) s = 12'($urandom);
        else if ($urandom_range(0, 3) == 0) s = m_score;
        else s = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        pulse(s);
        check($sformatf("rnd_err_%0d", i), 32'(bus.bcd_error), 32'(m_err));
      end
      probe_model($sformatf("rnd_%0d", i), int'($urandom_range(0, 95)), int'($urandom_range(0, 47)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
